// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector and the upstream
// shift register: direction encoding and collector FSM states.
package serial_word_collector_pkg;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/word_hold_reg.sv
// One-deep valid/ready holding register. A load that arrives while
// the register is full and not draining is refused and reported on drop.
module word_hold_reg #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         asyn_clr,
   input  logic         load,
   input  logic [N-1:0] din,
   input  logic         ready,
   output logic [N-1:0] dout,
   output logic         valid,
   output logic         drop
);

   logic [N-1:0] r_dout;
   logic         r_valid;
   logic         w_take;

   assign w_take = load & (~r_valid | ready);

   always_ff @(posedge clk or negedge asyn_clr) begin
      if (!asyn_clr) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else if (w_take) begin
         r_dout  <= din;
         r_valid <= 1'b1;
      end else if (r_valid & ready) begin
         r_valid <= 1'b0;
      end
   end

   assign dout  = r_dout;
   assign valid = r_valid;
   assign drop  = load & r_valid & ~ready;

endmodule

// File: rtl/serial_word_collector.sv
// Assembles N-bit words from the serial bit leaving a bidirectional
// shift register; bit order follows the latched shift direction.
module serial_word_collector
   import serial_word_collector_pkg::*;
#(
   parameter  int N  = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          asyn_clr,
   input  logic          ser_en,
   input  logic          ser_dir,
   input  logic          ser_in_l,
   input  logic          ser_in_r,
   input  logic          abort,
   output logic [N-1:0]  word_out,
   output logic          word_valid,
   input  logic          word_ready,
   output logic [CW-1:0] bit_cnt,
   output logic          overflow,
   output logic          dir_err,
   input  logic          clr_ovf
);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [N-1:0]  r_acc, w_acc_nxt;
   logic          r_dir, w_dir_nxt;
   logic          r_dir_err, w_dir_err_nxt;
   logic          r_ovf;
   logic          w_bit;
   logic [N-1:0]  w_shift;
   logic          w_load;
   logic          w_drop;

   assign w_bit   = (ser_dir == DIR_RIGHT) ? ser_in_r : ser_in_l;
   assign w_shift = (ser_dir == DIR_RIGHT) ? {r_acc[N-2:0], w_bit}
                                           : {w_bit, r_acc[N-1:1]};

   always_ff @(posedge clk or negedge asyn_clr) begin
      if (!asyn_clr) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_dir     <= DIR_LEFT;
         r_dir_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_acc     <= w_acc_nxt;
         r_dir     <= w_dir_nxt;
         r_dir_err <= w_dir_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_acc_nxt     = r_acc;
      w_dir_nxt     = r_dir;
      w_dir_err_nxt = 1'b0;
      w_load        = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end else if (ser_en) begin
         unique case (r_state)
            ST_IDLE: begin
               w_dir_nxt   = ser_dir;
               w_acc_nxt   = w_shift;
               w_cnt_nxt   = CW'(1);
               w_state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
               if (ser_dir != r_dir) begin
                  w_dir_err_nxt = 1'b1;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_acc_nxt = w_shift;
                  if (r_cnt == CW'(N - 1)) begin
                     w_load      = 1'b1;
                     w_cnt_nxt   = '0;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end
            end
         endcase
      end
   end

   // the completing bit is folded in here so the word lands one cycle later
   word_hold_reg #(
      .N(N)
   ) u_hold (
      .clk      (clk),
      .asyn_clr (asyn_clr),
      .load     (w_load),
      .din      (w_shift),
      .ready    (word_ready),
      .dout     (word_out),
      .valid    (word_valid),
      .drop     (w_drop)
   );

   always_ff @(posedge clk or negedge asyn_clr) begin
      if (!asyn_clr) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign bit_cnt  = r_cnt;
   assign overflow = r_ovf;
   assign dir_err  = r_dir_err;

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the N-bit bidirectional shift register: samples the serial bit leaving the register (left or right end) and assembles N-bit words.
- Bit order follows the shift direction.
- Completed words are presented on a one-deep valid/ready output buffer; a word that cannot be stored is dropped and flagged.
- Lets the shift register's serial output feed parallel consumers (bus, FIFO, compare logic).

Parameters:
N, 8, word width in bits; must match the upstream shift register width; N >= 2.
CW, $clog2(N+1), bit-counter width (derived, not overridden).

Ports:
clk  input  1  system clock; all state changes on rising edge.
asyn_clr  input  1  reset, asynchronous, active-low; 0 forces all state to reset values immediately.
ser_en  input  1  1 = a valid serial bit is present this cycle.
ser_dir  input  1  shift direction, same encoding as the shift register L_R: 1 = right (sample ser_in_r), 0 = left (sample ser_in_l).
ser_in_l  input  1  bit leaving the left end (shift register Dout_L).
ser_in_r  input  1  bit leaving the right end (shift register Dout_R).
abort  input  1  synchronous discard of any partial word.
word_out  output  N  assembled word; stable while word_valid=1.
word_valid  output  1  word_out holds an unconsumed word.
word_ready  input  1  consumer accepts word_out when word_valid and word_ready are both 1.
bit_cnt  output  CW  bits collected in the current partial word (0..N-1).
overflow  output  1  sticky; set when a completed word is dropped.
dir_err  output  1  one-cycle pulse; direction changed mid-word.
clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (asyn_clr=0): state=IDLE, bit_cnt=0, shift accumulator=0, word_out=0, word_valid=0, overflow=0, dir_err=0, latched direction=0.
- FSM states: IDLE (bit_cnt=0) and COLLECT (0<bit_cnt<N).
  - IDLE with ser_en=1: latch ser_dir, accept the first bit, bit_cnt=1, go to COLLECT.
- Bit selection: bit = ser_dir ? ser_in_r : ser_in_l.
- Accumulation, dir=1 (MSB first): acc <= {acc[N-2:0], bit}.
- Accumulation, dir=0 (LSB first): acc <= {bit, acc[N-1:1]}.
- COLLECT with ser_en=1 and ser_dir equal to the latched direction: accept the bit, bit_cnt+1.
- On the Nth bit, the completed word (acc plus this bit) goes to the output buffer, bit_cnt=0, go to IDLE.
  - Back-to-back words with no idle cycle are supported.
- COLLECT with ser_en=1 and ser_dir different from the latched direction: dir_err=1 for one cycle, partial word discarded, bit_cnt=0, go to IDLE. The offending bit is not used.
- ser_en=0: hold all state; no timeout.
- abort=1: bit_cnt=0, go to IDLE, same cycle's ser_en ignored. The output buffer is unaffected. abort has priority over ser_en.
- Output buffer load timing: word_valid rises the cycle after the Nth bit is sampled (latency 1).
- Buffer empty, or draining this cycle (word_valid & word_ready): load the word, word_valid=1.
- Buffer full and not draining: word dropped, overflow=1, word_out unchanged.
- Handshake with no new word: word_valid=0 the cycle after the handshake.
- word_out and word_valid must not change while word_valid=1 and word_ready=0.
- overflow: clr_ovf clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-word or mid-handshake discards everything immediately. No partial word survives.

Decomposition:
- Shared include header, used by the shift register and this block:
  - direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
  - state encodings ST_IDLE and ST_COLLECT.
- One natural sub-module: word_hold_reg, the one-deep valid/ready holding register.
  - Parameter N; ports clk, asyn_clr, load, din, ready, dout, valid, drop.
  - Instantiated once.

Test Plan (N=8):
- dir=1, ser_en=1 for 8 cycles, ser_in_r bits 1,0,1,1,0,0,1,0, word_ready=1 -> word_out=8'hB2, word_valid=1 exactly one cycle, starting the cycle after the 8th bit.
- dir=0, same bits on ser_in_l -> word_out=8'h4D.
- word_ready=0, two back-to-back words 8'hB2 then 8'hFF -> word_out stays 8'hB2, overflow=1 after the 16th bit. Then clr_ovf=1 -> overflow=0; word_ready=1 -> word_valid=0 next cycle.
- 3 bits at dir=1, then a bit with dir=0 -> dir_err pulse, bit_cnt=0. Next 8 bits at dir=0 produce a clean word, no corruption from the discarded bits.
- 5 bits collected, then abort=1 together with ser_en=1 -> bit_cnt=0, no word produced. Gaps (ser_en=0) inside a later word do not change its value.
- asyn_clr low mid-cycle during bit 4 and while word_valid=1 -> all outputs 0 immediately (asynchronously). After release, a full 8-bit word is required for the next word_valid.
